// File: rtl/plot_sink_fb.sv
// Plot-stream receiver: queues x/y/colour plots as linear framebuffer writes and
// provides a full-screen clear sweep. Optional bounds clipping under PLOT_CLIP_EN.
module plot_sink_fb #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int COLOUR_W   = 3,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                plot,
  input  logic [7:0]          x,
  input  logic [7:0]          y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                clear_req,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  input  logic                mem_ready,
  output logic                busy,
  output logic                full,
  output logic                overflow,
  output logic [7:0]          clip_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = ADDR_W + COLOUR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [PTR_W:0]    DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     clr_cnt_q, clr_cnt_d;
  logic                  clear_pending_q, clear_pending_d;
  logic [COLOUR_W-1:0]   clear_colour_q, clear_colour_d;
  logic [ENTRY_W-1:0]    fifo_mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]    fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic                  full_w, in_range, push, pop, clear_now;
  logic [ADDR_W-1:0]     plot_addr;
  logic [ENTRY_W-1:0]    head;

  assign full_w    = (count_q == DEPTH_CNT);
  assign plot_addr = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
  assign head      = fifo_mem_q[rd_ptr_q];
  assign push      = plot && in_range && !full_w;
  assign pop       = (state_q == S_DRAIN) && mem_ready;
  // A request arriving this cycle counts as pending so it pre-empts the next queued write.
  assign clear_now = clear_pending_q || clear_req;

`ifdef PLOT_CLIP_EN
  logic [7:0] clip_cnt_q, clip_cnt_d;
  assign in_range   = ({24'd0, x} < 32'(WIDTH)) && ({24'd0, y} < 32'(HEIGHT));
  assign clip_count = clip_cnt_q;
`else
  assign in_range   = 1'b1;
  assign clip_count = '0;
`endif

  always_comb begin
    state_d         = state_q;
    clr_cnt_d       = clr_cnt_q;
    clear_pending_d = clear_pending_q;
    clear_colour_d  = clear_colour_q;
    fifo_mem_d      = fifo_mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    overflow_d      = overflow_q;
`ifdef PLOT_CLIP_EN
    clip_cnt_d      = clip_cnt_q;
    if (plot && !in_range && clip_cnt_q != 8'hFF) clip_cnt_d = clip_cnt_q + 8'd1;
`endif

    if (push) begin
      fifo_mem_d[wr_ptr_q] = {plot_addr, colour};
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (plot && in_range && full_w) overflow_d = 1'b1;

    if (clear_req) begin
      clear_pending_d = 1'b1;
      clear_colour_d  = clear_colour;
    end

    case (state_q)
      S_IDLE: begin
        if (clear_now) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end else if (count_q != '0) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_ready) begin
          if (clear_now) begin
            state_d   = S_CLEAR;
            clr_cnt_d = '0;
          end else if (count_q == (PTR_W + 1)'(1) && !push) begin
            state_d = S_IDLE;
          end
        end
      end
      S_CLEAR: begin
        if (mem_ready) begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_ADDR) begin
            clear_pending_d = 1'b0;
            clr_cnt_d       = '0;
            state_d         = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      clr_cnt_q       <= '0;
      clear_pending_q <= 1'b0;
      clear_colour_q  <= '0;
      fifo_mem_q      <= '{default: '0};
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      overflow_q      <= 1'b0;
`ifdef PLOT_CLIP_EN
      clip_cnt_q      <= '0;
`endif
    end else begin
      state_q         <= state_d;
      clr_cnt_q       <= clr_cnt_d;
      clear_pending_q <= clear_pending_d;
      clear_colour_q  <= clear_colour_d;
      fifo_mem_q      <= fifo_mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      overflow_q      <= overflow_d;
`ifdef PLOT_CLIP_EN
      clip_cnt_q      <= clip_cnt_d;
`endif
    end
  end

  always_comb begin
    mem_we   = (state_q != S_IDLE);
    mem_addr = '0;
    mem_data = '0;
    if (state_q == S_DRAIN) begin
      mem_addr = head[ENTRY_W-1:COLOUR_W];
      mem_data = head[COLOUR_W-1:0];
    end else if (state_q == S_CLEAR) begin
      mem_addr = clr_cnt_q;
      mem_data = clear_colour_q;
    end
  end

  assign busy     = (state_q != S_IDLE) || (count_q != '0) || clear_pending_q;
  assign full     = full_w;
  assign overflow = overflow_q;

endmodule
